upb_input_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that merges the 256-bit streams of several 10G input blocks onto the single switch-core ingress stream.
- Sits between the per-port input blocks' arbiter_m_axis outputs and the datapath ingress, in the axi_aclk domain.
- Never interleaves beats of different packets.
- Forwards tuser_packet_length unchanged and keeps per-port packet counters for status.

---
 rtl/upb_axis_pkg.sv | 25 ++
 rtl/upb_rr_select.sv | 18 +
 rtl/upb_input_arbiter.sv | 95 +++++++++
 tb/tb_upb_input_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upb_axis_pkg.sv
// upb_axis_pkg: shared widths, arbiter state type and round-robin search helper
package upb_axis_pkg;
   localparam int DATA_W    = 256;
   localparam int KEEP_W    = DATA_W / 8;
   localparam int LEN_W     = 14;
   localparam int IDX_W     = 3;
   localparam int MAX_PORTS = 8;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   // First set bit of v at or above start, wrapping modulo n; 0 when v is empty.
   // Scanning k downward lets the smallest distance from start win.
   function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_PORTS-1:0] v,
                                                input logic [IDX_W-1:0] start,
                                                input int n);
      logic [IDX_W-1:0] r;
      int j;
      r = '0;
      for (int k = n - 1; k >= 0; k--) begin
         j = (int'(start) + k) % n;
         if (v[j[IDX_W-1:0]]) r = j[IDX_W-1:0];
      end
      return r;
   endfunction
endpackage

// File: rtl/upb_rr_select.sv
// upb_rr_select: combinational round-robin priority encoder
//   req   : request vector, one bit per port
//   start : index the search begins at (wraps modulo N)
//   idx   : first requesting index at or above start
//   any   : at least one request present
module upb_rr_select
   import upb_axis_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   assign idx = rr_next(MAX_PORTS'(req), start, N);
   assign any = |req;
endmodule

// File: rtl/upb_input_arbiter.sv
// upb_input_arbiter: packet-granular round-robin merge of N AXI-Stream slaves onto one master
//   axi_aclk/axi_reset : clock, asynchronous active-high reset
//   s_axis_*           : per-port slave streams, port i in slice i
//   m_axis_*           : merged stream plus src_port of the granted slave
//   pkt_count          : per-port count of forwarded packets (wraps)
module upb_input_arbiter
   import upb_axis_pkg::*;
#(
   parameter int C_NUM_PORTS  = 4,
   parameter int C_DATA_WIDTH = DATA_W,
   parameter int C_LEN_WIDTH  = LEN_W,
   parameter int C_CNT_WIDTH  = 32
) (
   input  logic                                axi_aclk,
   input  logic                                axi_reset,
   input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_NUM_PORTS-1:0]              s_axis_tuser,
   input  logic [C_NUM_PORTS*C_LEN_WIDTH-1:0]  s_axis_tuser_packet_length,
   input  logic [C_NUM_PORTS-1:0]              s_axis_tvalid,
   input  logic [C_NUM_PORTS-1:0]              s_axis_tlast,
   output logic [C_NUM_PORTS-1:0]              s_axis_tready,
   output logic [C_DATA_WIDTH-1:0]             m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]           m_axis_tkeep,
   output logic                                m_axis_tuser,
   output logic [C_LEN_WIDTH-1:0]              m_axis_tuser_packet_length,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic                                m_axis_tlast,
   output logic [IDX_W-1:0]                    m_axis_tuser_src_port,
   output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]  pkt_count
);
   localparam int KW = C_DATA_WIDTH / 8;
   localparam int SW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

   arb_state_t state, state_n;
   logic [IDX_W-1:0] grant, grant_n, rr_ptr, rr_ptr_n, grant_inc, start, sel_idx;
   logic [C_NUM_PORTS-1:0] req, gmask;
   logic [SW-1:0] g;
   logic busy, sel_any, hs_last;

   assign busy      = state == BUSY;
   assign g         = grant[SW-1:0];
   assign grant_inc = (int'(grant) == C_NUM_PORTS - 1) ? '0 : grant + 1'b1;
   assign gmask     = {{(C_NUM_PORTS-1){1'b0}}, 1'b1} << g;
   // While busy the search only matters at packet end and skips the finishing port,
   // so a lone requester drops back to IDLE and re-arbitrates from rr_ptr.
   assign start = busy ? grant_inc : rr_ptr;
   assign req   = busy ? s_axis_tvalid & ~gmask : s_axis_tvalid;

   upb_rr_select #(.N(C_NUM_PORTS)) u_sel (
      .req   (req),
      .start (start),
      .idx   (sel_idx),
      .any   (sel_any)
   );

   assign m_axis_tdata               = busy ? s_axis_tdata[g*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
   assign m_axis_tkeep               = busy ? s_axis_tkeep[g*KW +: KW] : '0;
   assign m_axis_tuser_packet_length = busy ? s_axis_tuser_packet_length[g*C_LEN_WIDTH +: C_LEN_WIDTH] : '0;
   assign m_axis_tuser               = busy & s_axis_tuser[g];
   assign m_axis_tvalid              = busy & s_axis_tvalid[g];
   assign m_axis_tlast               = busy & s_axis_tlast[g];
   assign m_axis_tuser_src_port      = grant;
   assign s_axis_tready              = (busy & m_axis_tready) ? gmask : '0;
   assign hs_last                    = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      rr_ptr_n = rr_ptr;
      if (!busy) begin
         state_n = sel_any ? BUSY : IDLE;
         grant_n = sel_any ? sel_idx : grant;
      end else if (hs_last) begin
         rr_ptr_n = grant_inc;
         state_n  = sel_any ? BUSY : IDLE;
         grant_n  = sel_any ? sel_idx : grant;
      end
   end

   always_ff @(posedge axi_aclk or posedge axi_reset) begin
      if (axi_reset) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         pkt_count <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         rr_ptr <= rr_ptr_n;
         if (hs_last) pkt_count[g*C_CNT_WIDTH +: C_CNT_WIDTH] <= pkt_count[g*C_CNT_WIDTH +: C_CNT_WIDTH] + 1'b1;
      end
   end
endmodule

// File: tb/tb_upb_input_arbiter.sv
// tb_upb_input_arbiter: directed self-checking bench for the packet round-robin arbiter
module tb_upb_input_arbiter;
   import upb_axis_pkg::*;
   localparam int NP = 4;
   localparam int DW = 256;
   localparam int KW = DW / 8;
   localparam int LW = 14;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NP*DW-1:0] s_tdata;
   logic [NP*KW-1:0] s_tkeep;
   logic [NP-1:0]    s_tuser, s_tvalid, s_tlast, s_tready;
   logic [NP*LW-1:0] s_len;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic             m_tuser, m_tvalid, m_tready, m_tlast;
   logic [LW-1:0]    m_len;
   logic [2:0]       m_src;
   logic [NP*CW-1:0] pkt_count;

   upb_input_arbiter #(.C_NUM_PORTS(NP), .C_DATA_WIDTH(DW), .C_LEN_WIDTH(LW), .C_CNT_WIDTH(CW)) dut (
      .axi_aclk                   (clk),
      .axi_reset                  (rst),
      .s_axis_tdata               (s_tdata),
      .s_axis_tkeep               (s_tkeep),
      .s_axis_tuser               (s_tuser),
      .s_axis_tuser_packet_length (s_len),
      .s_axis_tvalid              (s_tvalid),
      .s_axis_tlast               (s_tlast),
      .s_axis_tready              (s_tready),
      .m_axis_tdata               (m_tdata),
      .m_axis_tkeep               (m_tkeep),
      .m_axis_tuser               (m_tuser),
      .m_axis_tuser_packet_length (m_len),
      .m_axis_tvalid              (m_tvalid),
      .m_axis_tready              (m_tready),
      .m_axis_tlast               (m_tlast),
      .m_axis_tuser_src_port      (m_src),
      .pkt_count                  (pkt_count)
   );

   // source model and observed-stream scoreboard
   int pkts[NP], nb[NP], beat[NP], seq[NP], exp_beat[NP], exp_seq[NP];
   bit gap[NP];
   logic [LW-1:0] len[NP];
   int order[$];
   int n_cmp = 0, n_err = 0, idle_cnt, st;
   bit started;

   typedef struct {logic [NP-1:0] mask; int exp; logic [LW-1:0] ln;} vec_t;
   vec_t tbl[7];

   function automatic logic [DW-1:0] word(int p, int s, int b);
      return {8{8'(p), 8'(s), 8'(b), 8'h5A}};
   endfunction

   function automatic logic [KW-1:0] keep(int p, int b);
      return (b == nb[p] - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [CW-1:0] cnt(int p);
      return pkt_count[p*CW +: CW];
   endfunction

   function automatic bit pending();
      bit r;
      r = 0;
      for (int p = 0; p < NP; p++) if (pkts[p] > 0) r = 1;
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chkd(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) begin
         s_tvalid[p]          = pkts[p] > 0 && !gap[p];
         s_tlast[p]           = beat[p] == nb[p] - 1;
         s_tuser[p]           = seq[p] % 2 == 1;
         s_tdata[p*DW +: DW]  = word(p, seq[p], beat[p]);
         s_tkeep[p*KW +: KW]  = keep(p, beat[p]);
         s_len[p*LW +: LW]    = len[p];
      end
   endtask

   task automatic observe();
      int s;
      s = int'(m_src);
      if (s >= NP) begin
         chk("src_range", 64'(s), 64'(0));
         return;
      end
      if (exp_beat[s] == 0) begin
         if (order.size() == 0) chk("extra_pkt", 64'(s), 64'(99));
         else chk("grant_order", 64'(s), 64'(order.pop_front()));
      end
      chkd("data", m_tdata, word(s, exp_seq[s], exp_beat[s]));
      chk("keep", 64'(m_tkeep), 64'(keep(s, exp_beat[s])));
      chk("last", 64'(m_tlast), 64'(exp_beat[s] == nb[s] - 1));
      chk("length", 64'(m_len), 64'(len[s]));
      chk("tuser", 64'(m_tuser), 64'(exp_seq[s] % 2 == 1));
      chk("s_tready", 64'(s_tready), 64'(1 << s));
      if (exp_beat[s] == nb[s] - 1) begin
         exp_beat[s] = 0;
         exp_seq[s]++;
      end else exp_beat[s]++;
   endtask

   // one clock: sample at negedge, update sources #1 after posedge
   task automatic step();
      logic [NP-1:0] hs;
      @(negedge clk);
      hs = s_tvalid & s_tready;
      if (started && !m_tvalid) idle_cnt++;
      if (m_tvalid && m_tready) begin
         observe();
         started = 1;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) if (hs[p]) begin
         if (beat[p] == nb[p] - 1) begin
            beat[p] = 0;
            seq[p]++;
            pkts[p]--;
         end else beat[p]++;
      end
      drive();
   endtask

   task automatic run(int budget, output int steps);
      steps = 0;
      while (pending() && steps < budget) begin
         step();
         steps++;
      end
      if (pending()) chk("timeout", 64'(1), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < NP; p++) begin
         pkts[p] = 0; nb[p] = 1; beat[p] = 0; seq[p] = 0;
         exp_beat[p] = 0; exp_seq[p] = 0; gap[p] = 0; len[p] = LW'(64 + p);
      end
      order.delete();
      started = 0;
      idle_cnt = 0;
      m_tready = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{4'b0110, 1, 14'd64};
      tbl[1] = '{4'b1011, 3, 14'd100};
      tbl[2] = '{4'b1111, 0, 14'd1500};
      tbl[3] = '{4'b0001, 0, 14'd9000};
      tbl[4] = '{4'b1000, 3, 14'd60};
      tbl[5] = '{4'b0100, 2, 14'd16383};
      tbl[6] = '{4'b0011, 0, 14'd1};

      do_reset();
      chk("rst_tvalid", 64'(m_tvalid), 64'(0));
      chkd("rst_tdata", m_tdata, '0);
      chk("rst_tready", 64'(s_tready), 64'(0));
      chk("rst_src", 64'(m_src), 64'(0));
      chk("rst_count", 64'(pkt_count), 64'(0));

      // arbitration table: one single-beat packet per entry, rr_ptr carried across entries
      for (int i = 0; i < 7; i++) begin
         for (int p = 0; p < NP; p++) begin
            pkts[p] = tbl[i].mask[p] ? 1 : 0;
            len[p] = tbl[i].ln;
         end
         drive();
         #2 chk("tbl_idle_tvalid", 64'(m_tvalid), 64'(0));
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) if (p != tbl[i].exp) pkts[p] = 0;
         drive();
         order.push_back(tbl[i].exp);
         run(8, st);
      end
      chk("tbl_order_left", 64'(order.size()), 64'(0));
      chk("tbl_cnt0", 64'(cnt(0)), 64'(3));
      chk("tbl_cnt1", 64'(cnt(1)), 64'(1));
      chk("tbl_cnt2", 64'(cnt(2)), 64'(1));
      chk("tbl_cnt3", 64'(cnt(3)), 64'(2));

      // single port, 3 beats, length 80
      do_reset();
      nb[2] = 3; len[2] = 14'd80; pkts[2] = 1;
      order.push_back(2);
      drive();
      #2 chk("t1_latency", 64'(m_tvalid), 64'(0));
      run(20, st);
      chk("t1_steps", 64'(st), 64'(4));
      chk("t1_cnt2", 64'(cnt(2)), 64'(1));
      @(negedge clk);
      chk("t1_idle", 64'(m_tvalid), 64'(0));
      @(posedge clk);
      #1;

      // all ports continuously valid, 2-beat packets
      do_reset();
      for (int p = 0; p < NP; p++) begin
         nb[p] = 2; pkts[p] = 2;
      end
      for (int k = 0; k < 8; k++) order.push_back(k % NP);
      drive();
      run(40, st);
      chk("t2_bubbles", 64'(idle_cnt), 64'(0));
      chk("t2_order_left", 64'(order.size()), 64'(0));
      for (int p = 0; p < NP; p++) chk("t2_cnt", 64'(cnt(p)), 64'(2));

      // backpressure mid-packet with a competing requester
      do_reset();
      nb[1] = 4; pkts[1] = 1; nb[3] = 2;
      order.push_back(1); order.push_back(3);
      drive();
      for (int k = 0; k < 10 && exp_beat[1] < 2; k++) step();
      m_tready = 1'b0; pkts[3] = 1;
      drive();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t3_tready1", 64'(s_tready[1]), 64'(0));
         chk("t3_tready3", 64'(s_tready[3]), 64'(0));
         chk("t3_src", 64'(m_src), 64'(1));
         @(posedge clk);
         #1;
      end
      m_tready = 1'b1;
      run(20, st);
      chk("t3_order_left", 64'(order.size()), 64'(0));
      chk("t3_pkts1", 64'(exp_seq[1]), 64'(1));
      chk("t3_pkts3", 64'(exp_seq[3]), 64'(1));
      chk("t3_cnt1", 64'(cnt(1)), 64'(1));
      chk("t3_cnt3", 64'(cnt(3)), 64'(1));

      // source gap on the granted port
      do_reset();
      nb[0] = 4; pkts[0] = 1; nb[1] = 2; pkts[1] = 1;
      order.push_back(0); order.push_back(1);
      drive();
      for (int k = 0; k < 10 && exp_beat[0] < 1; k++) step();
      gap[0] = 1;
      drive();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t4_gap_tvalid", 64'(m_tvalid), 64'(0));
         chk("t4_gap_src", 64'(m_src), 64'(0));
         chk("t4_gap_tready1", 64'(s_tready[1]), 64'(0));
         @(posedge clk);
         #1;
      end
      gap[0] = 0;
      drive();
      run(20, st);
      chk("t4_order_left", 64'(order.size()), 64'(0));
      chk("t4_cnt0", 64'(cnt(0)), 64'(1));
      chk("t4_cnt1", 64'(cnt(1)), 64'(1));

      // asynchronous reset during beat 2 of 4
      do_reset();
      pkts[0] = 1;
      order.push_back(0);
      drive();
      run(10, st);
      chk("t5_pre_cnt0", 64'(cnt(0)), 64'(1));
      nb[2] = 4; pkts[2] = 1;
      order.push_back(2);
      drive();
      for (int k = 0; k < 10 && exp_beat[2] < 1; k++) step();
      #2 rst = 1'b1;
      #1;
      chk("t5_tvalid", 64'(m_tvalid), 64'(0));
      chkd("t5_tdata", m_tdata, '0);
      chk("t5_tlast", 64'(m_tlast), 64'(0));
      chk("t5_len", 64'(m_len), 64'(0));
      chk("t5_tready", 64'(s_tready), 64'(0));
      chk("t5_src", 64'(m_src), 64'(0));
      chk("t5_count", 64'(pkt_count), 64'(0));
      do_reset();
      nb[3] = 2; pkts[3] = 1;
      order.push_back(3);
      drive();
      run(20, st);
      chk("t5_order_left", 64'(order.size()), 64'(0));
      chk("t5_cnt3", 64'(cnt(3)), 64'(1));
      chk("t5_cnt2", 64'(cnt(2)), 64'(0));
      // rr_ptr now 0 after port 3; a fresh 0/3 contest must go to port 0
      pkts[0] = 1; pkts[3] = 1;
      order.push_back(0); order.push_back(3);
      drive();
      run(20, st);
      chk("t5_rr_order_left", 64'(order.size()), 64'(0));

      // 17 packets on port 0 with a 4-bit counter
      do_reset();
      pkts[0] = 17;
      for (int k = 0; k < 17; k++) order.push_back(0);
      drive();
      run(100, st);
      chk("t6_seen", 64'(exp_seq[0]), 64'(17));
      chk("t6_cnt_wrap", 64'(cnt(0)), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
